// File: rtl/occ_ram_stream_reader_if.sv
// RAM read-port and Avalon-ST source signals of the OCC RAM stream reader.
interface occ_ram_stream_reader_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_clken;
  logic [DATA_W-1:0] avm_readdata;
  logic [DATA_W-1:0] st_data;
  logic              st_valid;
  logic              st_ready;
  logic              st_startofpacket;
  logic              st_endofpacket;

  modport master (
    output avm_address, avm_chipselect, avm_clken,
    input  avm_readdata,
    output st_data, st_valid, st_startofpacket, st_endofpacket,
    input  st_ready
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_clken,
    output avm_readdata,
    input  st_data, st_valid, st_startofpacket, st_endofpacket,
    output st_ready
  );
endinterface

// File: rtl/occ_ram_stream_reader.sv
// Reads a wrap-around block from the 128x8 dual-port RAM (1-cycle latency)
// and emits it as a single Avalon-ST packet through a small credit-managed FIFO.
module occ_ram_stream_reader #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  output logic                busy,
  output logic                done,
  occ_ram_stream_reader_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] base_r;
  logic [LEN_W-1:0]  len_r, len_m1, issued, beat_cnt;
  logic              inflight;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, occupancy;
  logic              issue, push, pop, accept, zero_start, done_r;

  assign len_m1     = len_r - LEN_W'(1);
  assign occupancy  = count + CNT_W'(inflight);
  assign push       = inflight;
  assign pop        = bus.st_valid & bus.st_ready;
  assign accept     = (state == IDLE) & start & (length != '0);
  assign zero_start = (state == IDLE) & start & (length == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // A read is only issued when a FIFO slot is guaranteed for its data,
  // counting the one read that may still be in flight.
  always_comb begin
    state_n = state;
    issue   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_n = RUN;
      end
      RUN: begin
        if (occupancy < CNT_W'(FIFO_DEPTH)) begin
          issue = 1'b1;
          if (issued == len_m1) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && bus.st_endofpacket) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_r   <= '0;
      len_r    <= '0;
      issued   <= '0;
      beat_cnt <= '0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      done_r   <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      done_r   <= zero_start | ((state == DRAIN) & pop & bus.st_endofpacket);
      inflight <= issue;

      if (accept) begin
        base_r <= base_addr;
        len_r  <= length;
        issued <= '0;
      end else if (issue) begin
        issued <= issued + LEN_W'(1);
      end

      if (accept)   beat_cnt <= '0;
      else if (pop) beat_cnt <= beat_cnt + LEN_W'(1);

      if (push) begin
        mem[wr_ptr] <= bus.avm_readdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.avm_chipselect   = issue;
  assign bus.avm_clken        = issue;
  assign bus.avm_address      = base_r + issued[ADDR_W-1:0];
  assign bus.st_valid         = (count != '0);
  assign bus.st_data          = mem[rd_ptr];
  assign bus.st_startofpacket = bus.st_valid & (beat_cnt == '0);
  assign bus.st_endofpacket   = bus.st_valid & (beat_cnt == len_m1);

  assign busy = (state != IDLE);
  assign done = done_r;

endmodule

// File: doc/occ_ram_stream_reader.md
Name: occ_ram_stream_reader

Overview:
- Avalon-MM read master for the second port of the 128x8 on-chip dual-port RAM (chipselect/clken/address, fixed 1-cycle read latency, no waitrequest).
- On a start command, it reads a contiguous, wrap-around block of bytes and emits them as one Avalon-ST packet.
- A small internal FIFO handles sink backpressure.
- Sits between the shared RAM and the FPGA-side simulator datapath.

Parameters:
- ADDR_W, 7, RAM word-address width; depth = 2**ADDR_W.
- DATA_W, 8, RAM word and stream data width.
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only when busy=0.
- base_addr  in  ADDR_W  first RAM address, latched on start.
- length  in  ADDR_W+1  byte count, 0..2**ADDR_W, latched on start.
- busy  out  1  high from accepted start until the packet completes.
- done  out  1  one-cycle completion pulse.
- avm_address  out  ADDR_W  RAM address.
- avm_chipselect  out  1  read-issue qualifier.
- avm_clken  out  1  RAM clock enable; equals avm_chipselect.
- avm_readdata  in  DATA_W  RAM q, valid the cycle after issue.
- st_data  out  DATA_W  stream data (FIFO head).
- st_valid  out  1  stream valid.
- st_ready  in  1  sink ready; ready latency 0.
- st_startofpacket  out  1  first beat marker.
- st_endofpacket  out  1  last beat marker.

Behaviour:
- Reset (async assert, sync deassert at the next clk edge):
  - busy=0, done=0, avm_chipselect=0, avm_clken=0, avm_address=0.
  - st_valid=0, st_startofpacket=0, st_endofpacket=0, st_data=0.
  - FIFO empty; state IDLE; all counters cleared.
- Reset mid-operation: abort immediately. Emit no further beats and no done. The in-flight read is discarded.
- States: IDLE, RUN, DRAIN.
  - IDLE:
    - start=1, length!=0: latch base_addr/length; issue counter=0; go RUN; busy=1 next cycle.
    - start=1, length=0: stay IDLE, busy stays 0; done=1 the next cycle; no RAM access, no beats.
  - RUN:
    - Issue a read (avm_chipselect=1, address = base+issued mod 2**ADDR_W) only when fifo_count + inflight < FIFO_DEPTH. inflight is 0 or 1.
    - On the last issue, go DRAIN.
  - DRAIN: when the last beat handshakes (st_valid & st_ready & st_endofpacket), go IDLE.
  - start is ignored in RUN and DRAIN.
- Read timing:
  - Read issued in cycle N; avm_readdata captured into the FIFO at the end of cycle N+1.
  - Reads issue back-to-back while FIFO credit allows.
- Start-to-first-beat latency: start high in cycle 0 → first address in cycle 1 → data captured end of cycle 2 → st_valid=1 in cycle 3.
- Throughput: with st_ready held 1, one beat per cycle sustained; no bubbles after the first beat.
- Address wrap: (0x7F)+1 → 0x00; arithmetic modulo 2**ADDR_W.
- length=128: reads the entire RAM once, starting at base_addr.
- Stream rules:
  - st_startofpacket=1 only on beat 0; st_endofpacket=1 only on beat length-1. Both are set together when length=1.
  - st_data, st_valid and markers hold stable while st_valid=1 and st_ready=0.
  - FIFO never overflows; the credit rule guarantees this, and a bench assertion checks it.
- done/busy: done pulses 1 cycle in the cycle after the final handshake; busy falls in that same cycle.
- Writes: never issued; no write port exists.

Test Plan:
- Basic read: RAM[0x10..0x13] = {A1,B2,C3,D4}; base=0x10, len=4, st_ready=1 → st_valid in cycles 3..6 with data A1,B2,C3,D4; SOP on A1, EOP on D4; done in cycle 7; avm_address sequence 10,11,12,13.
- Wrap: base=0x7E, len=4 → addresses 7E,7F,00,01; data matches RAM contents.
- Backpressure: len=16, st_ready toggling 1,0,0,1 pattern → all 16 bytes delivered in order, no loss or duplication; FIFO occupancy never exceeds 4; data held stable during stalls.
- Zero length and busy-start: len=0 → done pulse next cycle, no chipselect, no st_valid. start pulsed mid-packet → ignored, base and length unchanged.
- Reset abort: len=32 with reset_n low after beat 5 → all outputs immediately 0. A fresh start with base=0x00, len=2 afterward delivers exactly 2 beats with SOP and EOP correct.
- Full RAM: len=128, base=0x40, st_ready=1 → 128 beats at 1 per cycle, addresses 40..7F then 00..3F, one done pulse.
